// File: rtl/trace_pkg.sv
// trace_pkg
// Shared types and constants for the instruction-trace capture buffer.
//   trace_entry_t     : one captured record {pc, ir, seq, ts}
//   SEQ_W / TS_W      : widths of the sequence number and timestamp fields
//   TRACE_ENTRY_NULL  : all-zero record presented when the FIFO is empty
package trace_pkg;

    localparam int SEQ_W = 16;
    localparam int TS_W  = 16;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      ir;
        logic [SEQ_W-1:0] seq;
        logic [TS_W-1:0]  ts;
    } trace_entry_t;

    localparam trace_entry_t TRACE_ENTRY_NULL = '{
        pc:  32'h0000_0000,
        ir:  32'h0000_0000,
        seq: 16'h0000,
        ts:  16'h0000
    };

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous FIFO of trace_entry_t records with flush.
//   clk, reset   : clock, asynchronous active-high reset
//   flush_i      : synchronous flush; wins over push and pop
//   push_i       : write request; accepted when not full, or full with a pop
//   pop_i        : read request; ignored while empty
//   wdata_i      : record to write
//   rdata_o      : head record, combinational; all zero when empty
//   count_o      : occupancy, full_o / empty_o : occupancy flags
//   push_ok_o    : push accepted this cycle, pop_ok_o : pop accepted this cycle
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  trace_entry_t  wdata_i,
    output trace_entry_t  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          push_ok_o,
    output logic          pop_ok_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    trace_entry_t  mem_q [DEPTH];

    logic full_s;
    logic empty_s;
    logic push_ok_s;
    logic pop_ok_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == CW'(0));

    // Accept logic: a push at full is allowed when a pop frees the slot the same edge.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (flush_i) begin
            pop_ok_s  = 1'b0;
            push_ok_s = 1'b0;
        end else begin
            pop_ok_s  = pop_i && !empty_s;
            push_ok_s = push_i && (!full_s || pop_ok_s);
        end
    end

    // Next-state for pointers and occupancy; pointers wrap modulo DEPTH naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            count_d  = CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are masked by the empty check on the read side.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o   = empty_s ? TRACE_ENTRY_NULL : mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign push_ok_o = push_ok_s;
    assign pop_ok_o  = pop_ok_s;

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer
// Instruction-trace capture buffer snooping the multicycle MIPS core.
// Records {pc, ir, seq, ts} on every enabled PC write, drained through a
// valid/ready port. Captures that find the FIFO full are dropped and counted;
// the core is never stalled.
//   clk, reset          : clock, asynchronous active-high reset
//   enable_i, clear_i   : capture enable, synchronous flush of all state
//   commit_i, pc_i, ir_i: core PC-write strobe, PC and IR
//   rd_valid_o/rd_ready_i, rd_pc_o, rd_ir_o, rd_seq_o, rd_ts_o : read port
//   count_o, full_o     : occupancy status
//   overflow_o          : sticky, set on first dropped capture
//   drop_cnt_o          : saturating count of dropped captures
// Optional feature: define TRACE_TIMESTAMP_EN to add a 16-bit free-running
// cycle counter stored per entry; otherwise rd_ts_o is tied to zero.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     commit_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              ir_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [31:0]              rd_pc_o,
    output logic [31:0]              rd_ir_o,
    output logic [SEQ_W-1:0]         rd_seq_o,
    output logic [TS_W-1:0]          rd_ts_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic         capture_s;
    logic         drop_s;
    logic         push_ok_s;
    logic         pop_ok_s;
    logic         fifo_empty_s;
    trace_entry_t wr_entry_s;
    trace_entry_t head_s;

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [TS_W-1:0]   ts_s;

    assign capture_s = commit_i && enable_i;
    // A capture the FIFO refused is a drop; a clear discards it without counting.
    assign drop_s    = capture_s && !push_ok_s && !clear_i;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // Free-running cycle counter; wraps, cleared by clear_i.
    always_comb begin
        ts_d = ts_q;
        if (clear_i) begin
            ts_d = 16'h0000;
        end else begin
            ts_d = ts_q + 16'h0001;
        end
    end

    // Timestamp counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= 16'h0000;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign ts_s    = ts_q;
    assign rd_ts_o = head_s.ts;
`else
    // The ts field is stored as a constant zero and never read back.
    logic unused_ts_s;

    assign ts_s        = 16'h0000;
    assign rd_ts_o     = 16'h0000;
    assign unused_ts_s = ^head_s.ts;
`endif

    assign wr_entry_s = '{pc: pc_i, ir: ir_i, seq: seq_q, ts: ts_s};

    // Sequence, overflow and drop-counter next state; seq advances on dropped captures too.
    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            seq_d      = 16'h0000;
            overflow_d = 1'b0;
            drop_cnt_d = {DROP_W{1'b0}};
        end else begin
            if (capture_s) begin
                seq_d = seq_q + 16'h0001;
            end else begin
                seq_d = seq_q;
            end
            if (drop_s) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != DROP_MAX) begin
                    drop_cnt_d = drop_cnt_q + {{(DROP_W-1){1'b0}}, 1'b1};
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end else begin
                overflow_d = overflow_q;
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Capture-side state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q      <= 16'h0000;
            overflow_q <= 1'b0;
            drop_cnt_q <= {DROP_W{1'b0}};
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (clear_i),
        .push_i    (capture_s),
        .pop_i     (rd_ready_i),
        .wdata_i   (wr_entry_s),
        .rdata_o   (head_s),
        .count_o   (count_o),
        .full_o    (full_o),
        .empty_o   (fifo_empty_s),
        .push_ok_o (push_ok_s),
        .pop_ok_o  (pop_ok_s)
    );

    // Head is presented straight from storage; the FIFO zeroes it when empty.
    assign rd_valid_o = !fifo_empty_s;
    assign rd_pc_o    = head_s.pc;
    assign rd_ir_o    = head_s.ir;
    assign rd_seq_o   = head_s.seq;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer
// Randomised and directed stimulus for trace_buffer, checked every cycle
// against a queue-based reference model of the trace buffer behaviour.
module tb_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_i;
    logic        clear_i;
    logic        commit_i;
    logic [31:0] pc_i;
    logic [31:0] ir_i;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [31:0] rd_pc_o;
    logic [31:0] rd_ir_o;
    logic [15:0] rd_seq_o;
    logic [15:0] rd_ts_o;
    logic [4:0]  count_o;
    logic        full_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (enable_i),
        .clear_i    (clear_i),
        .commit_i   (commit_i),
        .pc_i       (pc_i),
        .ir_i       (ir_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_pc_o    (rd_pc_o),
        .rd_ir_o    (rd_ir_o),
        .rd_seq_o   (rd_seq_o),
        .rd_ts_o    (rd_ts_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [15:0] seq;
        logic [15:0] ts;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_seq;
    logic [15:0] m_ts;
    logic [15:0] m_drop;
    bit          m_ovf;
    int          total = 0;
    int          bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_seq  = 16'h0;
        m_ts   = 16'h0;
        m_drop = 16'h0;
        m_ovf  = 1'b0;
    endtask

    // Behaviour at one rising edge, from the input values held across it.
    task automatic model_edge();
        bit   do_pop;
        bit   cap;
        ent_t e;
        if (clear_i) begin
            model_reset();
            return;
        end
        do_pop = (mq.size() != 0) && rd_ready_i;
        cap    = commit_i && enable_i;
        if (cap) begin
            if (mq.size() < DEPTH || do_pop) begin
                e.pc  = pc_i;
                e.ir  = ir_i;
                e.seq = m_seq;
                e.ts  = TS_ON ? m_ts : 16'h0;
                if (do_pop) void'(mq.pop_front());
                mq.push_back(e);
                do_pop = 1'b0;
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
            end
            m_seq = m_seq + 16'h1;
        end
        if (do_pop) void'(mq.pop_front());
        m_ts = m_ts + 16'h1;
    endtask

    task automatic compare_all();
        bit v;
        v = (mq.size() != 0);
        check_eq("rd_valid", rd_valid_o, v);
        check_eq("rd_pc",    rd_pc_o,    v ? mq[0].pc  : 32'h0);
        check_eq("rd_ir",    rd_ir_o,    v ? mq[0].ir  : 32'h0);
        check_eq("rd_seq",   rd_seq_o,   v ? mq[0].seq : 16'h0);
        check_eq("rd_ts",    rd_ts_o,    v ? mq[0].ts  : 16'h0);
        check_eq("count",    count_o,    mq.size());
        check_eq("full",     full_o,     mq.size() == DEPTH);
        check_eq("overflow", overflow_o, m_ovf);
        check_eq("drop_cnt", drop_cnt_o, m_drop);
    endtask

    // Drive one cycle of inputs, advance one edge, then check away from the edge.
    task automatic cycle(input bit c, input bit e, input bit r, input bit cl, input logic [31:0] pc);
        commit_i   = c;
        enable_i   = e;
        rd_ready_i = r;
        clear_i    = cl;
        pc_i       = pc;
        ir_i       = $urandom;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] ts_a;
        reset      = 1'b1;
        enable_i   = 1'b0;
        clear_i    = 1'b0;
        commit_i   = 1'b0;
        rd_ready_i = 1'b0;
        pc_i       = 32'h0;
        ir_i       = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        compare_all();

        // Three ordered captures, then drain.
        cycle(1, 1, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 32'h4);
        cycle(1, 1, 0, 0, 32'h8);
        check_eq("t1_count3", count_o, 5'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_seq", rd_seq_o, 16'(i));
            check_eq("t1_pc",  rd_pc_o,  32'(4 * i));
            cycle(0, 1, 1, 0, 32'h0);
        end
        check_eq("t1_count0", count_o, 5'd0);

        // Fill to full plus two drops.
        cycle(0, 1, 0, 1, 32'h0);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 1, 0, 0, 32'h1000 + 32'(4 * i));
        check_eq("t2_full", full_o, 1'b1);
        check_eq("t2_ovf",  overflow_o, 1'b1);
        check_eq("t2_drop", drop_cnt_o, 16'd2);
        check_eq("t2_head", rd_seq_o, 16'd0);
        // Push and pop together at full.
        cycle(1, 1, 1, 0, 32'hABC0);
        check_eq("t3_count", count_o, 5'd16);
        check_eq("t3_drop",  drop_cnt_o, 16'd2);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 1, 1, 0, 32'h0);
        check_eq("t3_last_seq", rd_seq_o, 16'd18);
        check_eq("t3_last_pc",  rd_pc_o,  32'hABC0);
        cycle(0, 1, 1, 0, 32'h0);

        // Disabled commits are ignored and seq frozen.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 32'h2000);
        check_eq("t4_count", count_o, 5'd0);
        cycle(1, 1, 0, 0, 32'h3000);
        check_eq("t4_seq", rd_seq_o, 16'd19);
        cycle(0, 1, 1, 0, 32'h0);

        // Timestamps of commits 10 cycles apart.
        cycle(1, 1, 0, 0, 32'h4000);
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 32'h4004);
        ts_a = rd_ts_o;
        cycle(0, 1, 1, 0, 32'h0);
        check_eq("t5_ts_diff", rd_ts_o - ts_a, TS_ON ? 16'd10 : 16'd0);
        cycle(0, 1, 1, 0, 32'h0);

        // Clear wins over a simultaneous commit.
        cycle(1, 1, 0, 0, 32'h5000);
        cycle(1, 1, 1, 1, 32'h5004);
        check_eq("t6_clear_count", count_o, 5'd0);
        check_eq("t6_clear_valid", rd_valid_o, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit hi_fill;
            hi_fill = ((i / 100) % 2) == 0;
            cycle(($urandom_range(0, 99) < 75),
                  ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < (hi_fill ? 30 : 70)),
                  ($urandom_range(0, 99) < 2),
                  $urandom);
        end

        // Asynchronous reset mid-drain with 7 entries held.
        cycle(0, 1, 0, 1, 32'h0);
        for (int i = 0; i < 9; i++) cycle(1, 1, 0, 0, 32'h6000 + 32'(4 * i));
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
        check_eq("t7_count7", count_o, 5'd7);
        #2 reset = 1'b1;
        #1;
        check_eq("t7_async_valid", rd_valid_o, 1'b0);
        check_eq("t7_async_count", count_o, 5'd0);
        check_eq("t7_async_pc",    rd_pc_o, 32'h0);
        #2 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++)
            cycle(($urandom_range(0, 1) == 1), 1'b1, ($urandom_range(0, 2) == 0), 1'b0, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Instruction-trace capture buffer that sits directly downstream of the multicycle MIPS core. It snoops the core's PC, instruction register and PC-write strobe, and records one entry for every cycle in which the PC is written. Entries are held in an on-chip FIFO and drained by a debug host through a valid/ready read port. Overflow is counted, never stalls the core, and never corrupts stored entries.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- DROP_W, 16: width of the dropped-entry counter; saturates at all-ones.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable_i  in  1  capture enable; sampled each cycle.
- clear_i  in  1  synchronous flush of FIFO, counters and flags.
- commit_i  in  1  capture strobe; connected to the core PC-write output.
- pc_i  in  32  core PC output.
- ir_i  in  32  core IR output.
- rd_valid_o  out  1  head entry available.
- rd_ready_i  in  1  host accepts head entry.
- rd_pc_o  out  32  PC field of head entry.
- rd_ir_o  out  32  IR field of head entry.
- rd_seq_o  out  16  sequence number of head entry.
- rd_ts_o  out  16  timestamp of head entry (see Configuration).
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  sticky; set on first dropped capture.
- drop_cnt_o  out  DROP_W  number of dropped captures, saturating.

## Operation
- Capture event: commit_i && enable_i at a rising edge. Record {pc_i, ir_i, seq, ts} is sampled on that edge.
- seq: 16-bit counter, incremented on every capture event, including dropped ones. It wraps 0xFFFF→0x0000, so gaps in rd_seq_o expose drops.
- Push is accepted if not full, or if full and a pop happens in the same cycle. The write pointer and read pointer wrap modulo DEPTH.
- Push rejected because full: entry discarded, overflow_o←1, drop_cnt_o incremented and held at 2^DROP_W−1.
- Pop: rd_valid_o && rd_ready_i. Read pointer advances. rd_ready_i while empty has no effect.
- Outputs rd_*_o show the head entry combinationally from storage. They are 0 when empty.
- clear_i resets pointers, count, seq, ts, overflow and drop counter. It wins over a simultaneous push or pop.
- enable_i low: no captures and seq frozen. Reads continue.
- Reset values: rd_valid_o 0, all rd_*_o 0, count_o 0, full_o 0, overflow_o 0, drop_cnt_o 0, seq 0, ts 0.

## Timing
- Capture-to-visible latency is 1 cycle: rd_valid_o rises the cycle after the accepted push into an empty FIFO.
- No fall-through: a push to an empty FIFO is never readable in the same cycle.
- Pop takes effect on the edge. The next entry is presented the following cycle.
- Push and pop in the same cycle: count unchanged. This holds at full, and both succeed.
- Throughput is 1 push plus 1 pop per cycle sustained.
- Asynchronous reset mid-drain or mid-capture discards all contents immediately. Outputs go to reset values without waiting for a clock edge.
- The read port never backpressures the core. commit_i is never ignored except by the drop rule.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - A 16-bit free-running cycle counter increments every clock; it is cleared by reset and clear_i and wraps.
  - Its value at the capture edge is stored per entry and presented on rd_ts_o.
- TRACE_TIMESTAMP_EN undefined:
  - No counter and no timestamp storage.
  - rd_ts_o is tied to 0.

## Structure
- Package trace_pkg:
  - typedef trace_entry_t {pc[31:0], ir[31:0], seq[15:0], ts[15:0]}.
  - Constants SEQ_W = 16 and TS_W = 16.
- Sub-module trace_fifo: a parameterised synchronous FIFO of trace_entry_t with push/pop/flush, count, full and empty.
- trace_buffer contains capture qualification, the seq/ts counters and overflow/drop logic.

## Test plan
- Reset, then 3 commits with pc = 0x0, 0x4, 0x8 and enable = 1 → 3 entries read with seq 0, 1, 2, matching pc/ir values, count_o 3→0.
- Fill FIFO to 16 entries, then 2 more commits → full_o = 1, overflow_o = 1, drop_cnt_o = 2, and the next read shows seq 0. seq 16 and 17 are absent; the next accepted capture is seq 18.
- At full, commit and pop in the same cycle → count_o stays 16, drop_cnt_o unchanged, and the new entry is last out.
- enable_i = 0 during 5 commits → count_o 0 and seq unchanged. Re-enable and commit → seq continues from the prior value.
- Assert reset asynchronously mid-drain with count 7 → rd_valid_o 0 and count_o 0 before the next edge. clear_i with a simultaneous commit → FIFO empty.
- With TRACE_TIMESTAMP_EN, commits 10 cycles apart → rd_ts_o difference is 10. Without the macro, rd_ts_o is 0.
